// File: rtl/montgomery_exp_ctrl_pkg.sv
// Shared definitions for the Montgomery exponentiation controller and the
// datapath operand muxes that decode its select codes.
package montgomery_exp_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_CONV_W,
    ST_SQ_I,
    ST_SQ_W,
    ST_MUL_I,
    ST_MUL_W,
    ST_FIN_I,
    ST_FIN_W,
    ST_DONE
  } state_e;

  localparam logic [1:0] SEL_A_X   = 2'd0;
  localparam logic [1:0] SEL_A_ACC = 2'd1;
  localparam logic [1:0] SEL_A_ONE = 2'd2;

  localparam logic [1:0] SEL_B_R2  = 2'd0;
  localparam logic [1:0] SEL_B_ACC = 2'd1;
  localparam logic [1:0] SEL_B_XT  = 2'd2;
  localparam logic [1:0] SEL_B_ONE = 2'd3;

  localparam logic ACC_SRC_RMODM = 1'b0;
  localparam logic ACC_SRC_MUL   = 1'b1;

endpackage

// File: rtl/montgomery_exp_ctrl_exp_bit_scanner.sv
// Latches the exponent and clamped scan length, then walks the bit index
// from the top scanned bit down to 0 without ever wrapping.
module exp_bit_scanner #(
  parameter int EXP_W = 512,
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [EXP_W-1:0] exponent_i,
  input  logic [LEN_W-1:0] exp_len_i,
  output logic             bit_o,
  output logic             last_o,
  output logic             len_zero_o
);

  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  logic [EXP_W-1:0] exp_q;
  logic [IDX_W-1:0] idx_q;
  logic             len_zero_q;

  logic [31:0]      len_ext;
  logic [31:0]      len_clamped;
  logic [IDX_W-1:0] idx_load;

  // A length of zero loads index 0 and is flagged so the FSM skips the loop.
  always_comb begin
    len_ext     = 32'(exp_len_i);
    len_clamped = (len_ext > 32'(EXP_W)) ? 32'(EXP_W) : len_ext;
    idx_load    = (len_clamped == 32'd0) ? '0 : IDX_W'(len_clamped - 32'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q      <= '0;
      idx_q      <= '0;
      len_zero_q <= 1'b0;
    end else if (load_i) begin
      exp_q      <= exponent_i;
      idx_q      <= idx_load;
      len_zero_q <= (len_clamped == 32'd0);
    end else if (step_i && (idx_q != '0)) begin
      idx_q <= idx_q - 1'b1;
    end
  end

  assign bit_o      = exp_q[idx_q];
  assign last_o     = (idx_q == '0);
  assign len_zero_o = len_zero_q;

endmodule

// File: rtl/montgomery_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one shared Montgomery
// multiplier: conversion, scan loop, and final conversion out of the domain.
module montgomery_exp_ctrl
  import montgomery_exp_ctrl_pkg::*;
#(
  parameter int EXP_W = 512,
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [EXP_W-1:0] exponent,
  input  logic [LEN_W-1:0] exp_len,
  output logic             busy,
  output logic             done,
  output logic             mul_start,
  input  logic             mul_done,
  output logic [1:0]       sel_a,
  output logic [1:0]       sel_b,
  output logic             acc_src,
  output logic             acc_we,
  output logic             xt_we
);

  state_e state_q, state_d;
  logic   scan_load, scan_step, scan_bit, scan_last, scan_len_zero;

  exp_bit_scanner #(.EXP_W(EXP_W), .LEN_W(LEN_W)) u_scanner (
    .clk        (clk),
    .reset      (reset),
    .load_i     (scan_load),
    .step_i     (scan_step),
    .exponent_i (exponent),
    .exp_len_i  (exp_len),
    .bit_o      (scan_bit),
    .last_o     (scan_last),
    .len_zero_o (scan_len_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    mul_start = 1'b0;
    sel_a     = SEL_A_X;
    sel_b     = SEL_B_R2;
    acc_src   = ACC_SRC_RMODM;
    acc_we    = 1'b0;
    xt_we     = 1'b0;
    scan_load = 1'b0;
    scan_step = 1'b0;
    // Outputs are gated by reset so nothing leaks while a run is being aborted.
    if (reset) begin
      state_d = ST_IDLE;
    end else begin
      busy = (state_q != ST_IDLE);
      unique case (state_q)
        ST_IDLE: if (start) begin
          scan_load = 1'b1;
          state_d   = ST_INIT;
        end
        ST_INIT: begin
          acc_we    = 1'b1;
          mul_start = 1'b1;
          state_d   = ST_CONV_W;
        end
        ST_CONV_W: if (mul_done) begin
          xt_we   = 1'b1;
          state_d = scan_len_zero ? ST_FIN_I : ST_SQ_I;
        end
        ST_SQ_I, ST_SQ_W: begin
          sel_a = SEL_A_ACC;
          sel_b = SEL_B_ACC;
          if (state_q == ST_SQ_I) begin
            mul_start = 1'b1;
            state_d   = ST_SQ_W;
          end else if (mul_done) begin
            acc_we  = 1'b1;
            acc_src = ACC_SRC_MUL;
            if (scan_bit)       state_d = ST_MUL_I;
            else if (scan_last) state_d = ST_FIN_I;
            else begin
              scan_step = 1'b1;
              state_d   = ST_SQ_I;
            end
          end
        end
        ST_MUL_I, ST_MUL_W: begin
          sel_a = SEL_A_ACC;
          sel_b = SEL_B_XT;
          if (state_q == ST_MUL_I) begin
            mul_start = 1'b1;
            state_d   = ST_MUL_W;
          end else if (mul_done) begin
            acc_we  = 1'b1;
            acc_src = ACC_SRC_MUL;
            if (scan_last) state_d = ST_FIN_I;
            else begin
              scan_step = 1'b1;
              state_d   = ST_SQ_I;
            end
          end
        end
        ST_FIN_I, ST_FIN_W: begin
          sel_a = SEL_A_ACC;
          sel_b = SEL_B_ONE;
          if (state_q == ST_FIN_I) begin
            mul_start = 1'b1;
            state_d   = ST_FIN_W;
          end else if (mul_done) begin
            acc_we  = 1'b1;
            acc_src = ACC_SRC_MUL;
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_exp_ctrl.sv
// Directed bench for montgomery_exp_ctrl with a fixed-latency multiplier stub.
module tb_montgomery_exp_ctrl;
  import montgomery_exp_ctrl_pkg::*;

  localparam int EXP_W = 512;
  localparam int LEN_W = 10;

  logic             clk = 1'b0;
  logic             reset, start;
  logic             mul_done = 1'b0;
  logic [EXP_W-1:0] exponent;
  logic [LEN_W-1:0] exp_len;
  logic             busy, done, mul_start, acc_src, acc_we, xt_we;
  logic [1:0]       sel_a, sel_b;

  int checks = 0, passed = 0;
  int cyc = 0, busy_tot = 0, acc_tot = 0, rmodm_tot = 0, xt_tot = 0;
  int done_tot = 0, last_acc_cyc = 0, done_cyc = 0;
  logic [3:0] op_log[$];
  logic [3:0] run_ops[$];
  int   r_busy, r_acc, r_rmodm, r_xt, r_done, r_gap;
  int   stub_cnt = 0;
  logic stub_pend = 1'b0;
  logic spurious_done = 1'b0;

  // Operation codes are {sel_a, sel_b} at each mul_start.
  localparam logic [3:0] OP_CONV = 4'h0, OP_S = 4'h5, OP_M = 4'h6, OP_FIN = 4'h7;
  localparam logic [3:0] SEQ_B7[16] = '{OP_CONV, OP_S, OP_M, OP_S, OP_S, OP_M, OP_S, OP_M,
                                        OP_S, OP_S, OP_M, OP_S, OP_M, OP_S, OP_M, OP_FIN};
  localparam logic [3:0] SEQ_BB[16] = '{OP_CONV, OP_S, OP_M, OP_S, OP_S, OP_M, OP_S, OP_M,
                                        OP_S, OP_M, OP_S, OP_S, OP_M, OP_S, OP_M, OP_FIN};

  montgomery_exp_ctrl #(.EXP_W(EXP_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .exponent(exponent), .exp_len(exp_len),
    .busy(busy), .done(done), .mul_start(mul_start), .mul_done(mul_done),
    .sel_a(sel_a), .sel_b(sel_b), .acc_src(acc_src), .acc_we(acc_we), .xt_we(xt_we)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    stub_pend = mul_start;
    if (busy) busy_tot++;
    if (mul_start) op_log.push_back({sel_a, sel_b});
    if (acc_we) begin
      acc_tot++;
      last_acc_cyc = cyc;
      if (!acc_src) rmodm_tot++;
    end
    if (xt_we) xt_tot++;
    if (done) begin
      done_tot++;
      done_cyc = cyc;
    end
  end

  // mul_done rises exactly 3 cycles after the cycle in which mul_start was high.
  always @(posedge clk) begin
    #1;
    mul_done = 1'b0;
    if (reset) stub_cnt = 0;
    else begin
      if (stub_cnt != 0) begin
        stub_cnt--;
        if (stub_cnt == 0) mul_done = 1'b1;
      end
      if (stub_pend) stub_cnt = 2;
    end
    if (spurious_done) mul_done = 1'b1;
  end

  // mode 0: plain run; 1: pulse start in each MUL_W; 2: hold start across FIN_W end and DONE.
  task automatic do_run(input logic [EXP_W-1:0] e, input logic [LEN_W-1:0] len,
                        input int mode, output bit ok);
    int  ob, bb, ab, rb, xb, db;
    bit  poke_next;
    ob = op_log.size(); bb = busy_tot; ab = acc_tot; rb = rmodm_tot; xb = xt_tot; db = done_tot;
    poke_next = 1'b0;
    ok = 1'b0;
    exponent = e; exp_len = len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (poke_next) begin
        start = 1'b1;
        poke_next = 1'b0;
      end else if (mode == 1) start = 1'b0;
      if (mode == 1 && mul_start && sel_b == SEL_B_XT) poke_next = 1'b1;
      if (mode == 2 && acc_we && sel_b == SEL_B_ONE) start = 1'b1;
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    run_ops.delete();
    for (int i = ob; i < op_log.size(); i++) run_ops.push_back(op_log[i]);
    r_busy = busy_tot - bb; r_acc = acc_tot - ab; r_rmodm = rmodm_tot - rb;
    r_xt = xt_tot - xb; r_done = done_tot - db; r_gap = done_cyc - last_acc_cyc;
    checks++;
    if (!ok) $display("FAIL run_complete: done not seen within 4000 cycles (exp_len=%0d)", len);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; spurious_done = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, mul_start, acc_we, xt_we, sel_a, sel_b, acc_src} !== 10'b0)
      $display("FAIL reset_outputs: got %b expected 0", {busy, done, mul_start, acc_we, xt_we, sel_a, sel_b, acc_src});
    else passed++;
    start = 1'b0; spurious_done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b expected 0", busy);
    else passed++;
  endtask

  task automatic test_basic();
    bit ok;
    int errs;
    do_run(512'hB7, 10'd8, 0, ok);
    errs = 0;
    for (int i = 0; i < 16; i++) if (i >= run_ops.size() || run_ops[i] !== SEQ_B7[i]) errs++;
    checks++;
    if (run_ops.size() != 16 || errs != 0)
      $display("FAIL b7_sequence: %0d ops, %0d mismatched, expected 16 ops in order", run_ops.size(), errs);
    else passed++;
    checks++;
    if (r_busy != 65) $display("FAIL b7_busy_cycles: got %0d expected 65", r_busy);
    else passed++;
    checks++;
    if (r_acc != 16 || r_rmodm != 1) $display("FAIL b7_acc_we: got %0d (rmodm %0d) expected 16 (1)", r_acc, r_rmodm);
    else passed++;
    checks++;
    if (r_xt != 1) $display("FAIL b7_xt_we: got %0d expected 1", r_xt);
    else passed++;
    checks++;
    if (r_done != 1 || r_gap != 1) $display("FAIL b7_done: count %0d gap %0d expected 1 and 1", r_done, r_gap);
    else passed++;
  endtask

  task automatic test_len_zero();
    bit ok;
    do_run(512'hFF, 10'd0, 0, ok);
    checks++;
    if (run_ops.size() != 2 || run_ops[0] !== OP_CONV || run_ops[1] !== OP_FIN)
      $display("FAIL len0_ops: got %0d ops expected CONV,FIN", run_ops.size());
    else passed++;
    checks++;
    if (r_busy != 9 || r_done != 1) $display("FAIL len0_timing: busy %0d done %0d expected 9 and 1", r_busy, r_done);
    else passed++;
  endtask

  task automatic test_partial_len();
    bit ok;
    do_run(512'hFF, 10'd4, 0, ok);
    checks++;
    if (run_ops.size() != 10) $display("FAIL len4_pulses: got %0d expected 10", run_ops.size());
    else passed++;
  endtask

  task automatic test_clamp();
    bit ok;
    logic [EXP_W-1:0] e;
    e = (512'h1 << 511) | 512'hF1;
    do_run(e, 10'd600, 0, ok);
    checks++;
    if (run_ops.size() != 520) $display("FAIL clamp_pulses: got %0d expected 520", run_ops.size());
    else passed++;
    checks++;
    if (r_busy != 2081) $display("FAIL clamp_busy: got %0d expected 2081", r_busy);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int errs, ob;
    ob = op_log.size();
    exponent = 512'hBB; exp_len = 10'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && op_log.size() < ob + 2; i++) @(negedge clk);
    checks++;
    if (op_log.size() < ob + 2) $display("FAIL mid_reach_sq: only %0d ops seen", op_log.size() - ob);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, mul_start, acc_we, xt_we, sel_a, sel_b, acc_src} !== 10'b0)
      $display("FAIL mid_reset_outputs: got %b expected 0 during SQ_W", {busy, done, mul_start, acc_we, xt_we, sel_a, sel_b, acc_src});
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mul_start !== 1'b0) $display("FAIL mid_reset_idle: busy=%b mul_start=%b expected 0", busy, mul_start);
    else passed++;
    do_run(512'hBB, 10'd8, 0, ok);
    errs = 0;
    for (int i = 0; i < 16; i++) if (i >= run_ops.size() || run_ops[i] !== SEQ_BB[i]) errs++;
    checks++;
    if (run_ops.size() != 16 || errs != 0)
      $display("FAIL bb_rerun: %0d ops, %0d mismatched, expected 16 in order", run_ops.size(), errs);
    else passed++;
  endtask

  task automatic test_ignore();
    bit ok;
    int ob, errs;
    ob = op_log.size();
    spurious_done = 1'b1;
    @(negedge clk);
    spurious_done = 1'b0;
    checks++;
    if (busy !== 1'b0 || acc_we !== 1'b0 || xt_we !== 1'b0 || mul_done !== 1'b1)
      $display("FAIL idle_mul_done: busy=%b acc_we=%b xt_we=%b mul_done=%b expected 0,0,0,1", busy, acc_we, xt_we, mul_done);
    else passed++;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || op_log.size() != ob) $display("FAIL idle_stays: busy=%b ops=%0d expected 0 and 0", busy, op_log.size() - ob);
    else passed++;
    do_run(512'hB7, 10'd8, 1, ok);
    errs = 0;
    for (int i = 0; i < 16; i++) if (i >= run_ops.size() || run_ops[i] !== SEQ_B7[i]) errs++;
    checks++;
    if (run_ops.size() != 16 || errs != 0 || r_busy != 65)
      $display("FAIL start_in_mulw: %0d ops, %0d mismatched, busy %0d expected 16, 0, 65", run_ops.size(), errs, r_busy);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_run(512'h5, 10'd3, 2, ok);
    checks++;
    if (busy !== 1'b0 || run_ops.size() != 7) $display("FAIL start_in_done: busy=%b ops=%0d expected 0 and 7", busy, run_ops.size());
    else passed++;
    do_run(512'h5, 10'd3, 0, ok);
    checks++;
    if (run_ops.size() != 7 || r_busy != 29) $display("FAIL restart_after_done: ops %0d busy %0d expected 7 and 29", run_ops.size(), r_busy);
    else passed++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; exponent = '0; exp_len = '0;
    test_reset();
    test_basic();
    test_len_zero();
    test_partial_len();
    test_clamp();
    test_reset_mid();
    test_ignore();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/montgomery_exp_ctrl.md
MONTGOMERY_EXP_CTRL -- requirements
Module: montgomery_exp_ctrl

Interface
REQ-001 The block SHALL have parameter EXP_W, default 512, meaning exponent register width.
REQ-002 The block SHALL have parameter LEN_W, default 10, meaning width of exp_len.
REQ-003 The block SHALL have a single clock and a synchronous, active-high reset, named as listed below.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 start  in  1  request; sampled only in IDLE.
REQ-007 exponent  in  EXP_W  exponent, latched on accepted start.
REQ-008 exp_len  in  LEN_W  number of exponent bits to scan; latched on accepted start.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 mul_start  out  1  one-cycle pulse that launches the shared Montgomery multiplier.
REQ-012 mul_done  in  1  one-cycle multiplier completion pulse.
REQ-013 sel_a  out  2  operand-A select: X, ACC, ONE.
REQ-014 sel_b  out  2  operand-B select: R2, ACC, XT, ONE.
REQ-015 acc_src  out  1  accumulator load source: 0 = Rmodm, 1 = multiplier result.
REQ-016 acc_we  out  1  accumulator write enable.
REQ-017 xt_we  out  1  x-tilde register write enable (multiplier result).

Function
REQ-018 States SHALL be IDLE, INIT, CONV_W, SQ_I, SQ_W, MUL_I, MUL_W, FIN_I, FIN_W and DONE.
REQ-019 In IDLE with start=1, the block SHALL latch exponent and min(exp_len, EXP_W), set bit index = len-1, and go to INIT.
REQ-020 In INIT, the block SHALL assert acc_we with acc_src=0 (ACC := Rmodm), pulse mul_start with sel_a=X, sel_b=R2, and go to CONV_W.
REQ-021 In every *_W state, the block SHALL hold sel_a/sel_b at their issue values and wait for mul_done.
REQ-022 In CONV_W with mul_done, the block SHALL assert xt_we, then go to SQ_I if len>0, else to FIN_I.
REQ-023 In SQ_I, the block SHALL pulse mul_start with sel_a=ACC, sel_b=ACC.
REQ-024 In SQ_W with mul_done, the block SHALL assert acc_we with acc_src=1, then go to MUL_I if exponent[index]=1, else take the loop step.
REQ-025 In MUL_I, the block SHALL pulse mul_start with sel_a=ACC, sel_b=XT.
REQ-026 In MUL_W with mul_done, the block SHALL assert acc_we with acc_src=1, then take the loop step.
REQ-027 Loop step: if index=0, go to FIN_I; else decrement index and go to SQ_I.
REQ-028 In FIN_I, the block SHALL pulse mul_start with sel_a=ACC, sel_b=ONE.
REQ-029 In FIN_W with mul_done, the block SHALL assert acc_we with acc_src=1 and go to DONE.
REQ-030 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-031 acc_we and xt_we SHALL be combinational, asserted only in the cycle mul_done=1 in the matching W state.
REQ-032 Total mul_start pulses per run SHALL be 2 + len + popcount(exponent[len-1:0]).
REQ-033 Overhead beyond multiplier latency SHALL be exactly 1 issue cycle per operation plus the DONE cycle.
REQ-034 start outside IDLE SHALL be ignored.
REQ-035 mul_done outside a W state SHALL be ignored.
REQ-036 start arriving in the DONE cycle SHALL be ignored; start is accepted again from the following IDLE cycle.
REQ-037 Bit index arithmetic SHALL never wrap below 0.

Reset
REQ-038 reset=1 SHALL force IDLE and clear the index and latched exponent/length, from any state including mid-operation.
REQ-039 While reset=1, busy, done, mul_start, acc_we and xt_we SHALL be 0, and sel_a, sel_b and acc_src SHALL be 0.

Structure
REQ-040 A shared package SHALL hold the state enumeration and the SEL_A_*/SEL_B_* operand codes, for reuse by the datapath mux.
REQ-041 Bit-index and exponent latching SHALL live in one sub-module, exp_bit_scanner (load, step, current bit, last flag).
REQ-042 The multiplier and operand muxes SHALL be external to this block.

Verification
REQ-043 Stub multiplier, mul_done exactly 3 cycles after mul_start; exponent=0xB7, exp_len=8 -> 16 mul_start pulses; op order CONV,S,M,S,S,M,S,M,S,S,M,S,M,S,M,FIN; done 1 cycle after final acc_we.
REQ-044 exp_len=0 -> exactly 2 mul_start pulses (CONV, FIN), then done; no SQ/MUL state entered.
REQ-045 exp_len=600 with EXP_W=512 -> scan clamped to 512 bits; pulse count per REQ-032.
REQ-046 reset during SQ_W of a 0xBB run -> IDLE next cycle, all outputs 0; a new start with 0xBB then completes normally.
REQ-047 start pulsed during MUL_W, plus a spurious mul_done in IDLE -> no state change and no extra mul_start.
REQ-048 Integrated with the 512-bit Montgomery multiplier, exponent=0xBB, random odd 512-bit m -> accumulator equals x^0xBB mod m from the bench golden model.
